sram_access_ctrl: RTL and testbench

- Sequences single-word read/write transactions to the external 16-bit asynchronous SRAM.
- Sits directly upstream of the memory-to-register data steering stage: it produces the CE/UB/LB/OE/WE strobes and address that the steering stage decodes.
- Accepts requests from the game logic (frame buffer / trail map) over a valid/ready handshake and returns read data with a one-cycle response pulse.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_wait_counter.sv | 27 ++
 rtl/sram_access_ctrl.sv | 156 +++++++++++++++
 tb/tb_sram_access_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared state, request and width definitions for the async SRAM access controller.
package sram_pkg;

  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } sram_state_t;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic [1:0]             be;
  } sram_req_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with a terminal-count flag; times the SRAM ACCESS phase.
module sram_wait_counter #(
  parameter int CNT_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-word read/write sequencer for a 16-bit async SRAM (IDLE/SETUP/ACCESS/HOLD).
// Optional per-byte strobes on UB/LB are enabled with `define SRAM_BYTE_MASK_EN.
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [SRAM_DATA_W-1:0] req_wdata,
  input  logic [1:0]             req_be,
  output logic                   rsp_valid,
  output logic [SRAM_DATA_W-1:0] rsp_rdata,
  output logic                   CE,
  output logic                   UB,
  output logic                   LB,
  output logic                   OE,
  output logic                   WE,
  output logic [ADDR_W-1:0]      SRAM_ADDR,
  output logic [SRAM_DATA_W-1:0] Data_to_SRAM,
  input  logic [SRAM_DATA_W-1:0] Data_from_SRAM,
  output logic                   sram_drive
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("sram_access_ctrl: WAIT_CYCLES must be at least 1");
  end
  if (ADDR_W > SRAM_ADDR_W) begin : g_bad_addr
    $error("sram_access_ctrl: ADDR_W exceeds SRAM_ADDR_W");
  end

  sram_state_t           r_state;
  sram_req_t             r_req;
  sram_req_t             w_req;
  logic                  r_ready;
  logic                  r_rsp_valid;
  logic [SRAM_DATA_W-1:0] r_rdata;
  logic                  r_ce_n;
  logic                  r_ub_n;
  logic                  r_lb_n;
  logic                  r_oe_n;
  logic                  r_we_n;
  logic                  r_drive;
  logic [1:0]            w_lane_n;
  logic                  w_cnt_load;
  logic                  w_cnt_dec;
  logic                  w_cnt_zero;
  logic                  w_unused_be;

  assign w_req = '{we: req_we, addr: SRAM_ADDR_W'(req_addr), wdata: req_wdata, be: req_be};

`ifdef SRAM_BYTE_MASK_EN
  assign w_lane_n = ~req_be;
`else
  assign w_lane_n = 2'b00;
`endif

  // The latched byte enables only steer the lane strobes, which are registered at accept.
  assign w_unused_be = ^r_req.be;

  assign w_cnt_load = (r_state == SETUP);
  assign w_cnt_dec  = (r_state == ACCESS);

  sram_wait_counter #(
    .CNT_W(CNT_W)
  ) u_wait_counter (
    .i_clk      (Clk),
    .i_rst      (Reset),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_W'(WAIT_CYCLES - 1)),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_ce_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_lb_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_drive     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && r_ready) begin
            r_req   <= w_req;
            r_state <= SETUP;
            r_ready <= 1'b0;
            r_ce_n  <= 1'b0;
            r_ub_n  <= w_lane_n[1];
            r_lb_n  <= w_lane_n[0];
            r_oe_n  <= req_we;
            r_drive <= req_we;
          end
        end
        SETUP: begin
          // Address and data have had a full cycle of setup before WE falls.
          r_state <= ACCESS;
          if (r_req.we) begin
            r_we_n <= 1'b0;
          end
        end
        ACCESS: begin
          if (w_cnt_zero) begin
            r_state     <= HOLD;
            r_rsp_valid <= 1'b1;
            if (r_req.we) begin
              r_we_n <= 1'b1;
            end else begin
              r_oe_n  <= 1'b1;
              r_rdata <= Data_from_SRAM;
            end
          end
        end
        HOLD: begin
          r_state     <= IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_ce_n      <= 1'b1;
          r_ub_n      <= 1'b1;
          r_lb_n      <= 1'b1;
          r_oe_n      <= 1'b1;
          r_we_n      <= 1'b1;
          r_drive     <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready    = r_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rdata;
  assign CE           = r_ce_n;
  assign UB           = r_ub_n;
  assign LB           = r_lb_n;
  assign OE           = r_oe_n;
  assign WE           = r_we_n;
  assign SRAM_ADDR    = r_req.addr[ADDR_W-1:0];
  assign Data_to_SRAM = r_req.wdata;
  assign sram_drive   = r_drive;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl with a behavioural async SRAM model.
module tb_sram_access_ctrl;

  parameter int WAIT_CYCLES = 2;
  localparam int ADDR_W = 20;

  typedef struct {
    bit          we;
    logic [15:0] rdata;
    int          acc;
  } rsp_exp_t;

  typedef struct {
    bit          we;
    logic [15:0] wdata;
    bit          ub_n;
    bit          lb_n;
  } str_exp_t;

  logic              Clk;
  logic              Reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic [1:0]        req_be;
  logic              rsp_valid;
  logic [15:0]       rsp_rdata;
  logic              CE, UB, LB, OE, WE;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [15:0]       Data_to_SRAM;
  logic [15:0]       Data_from_SRAM;
  logic              sram_drive;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rsp = 0;
  int n_issued = 0;
  bit busy = 0;
  bit mask_en;

  logic [15:0] mem [256];
  logic        prev_we_n = 1'b1;
  logic [15:0] last_rd = 16'h0;

  rsp_exp_t q_rsp [$];
  str_exp_t q_str [$];

  sram_access_ctrl #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .CE             (CE),
    .UB             (UB),
    .LB             (LB),
    .OE             (OE),
    .WE             (WE),
    .SRAM_ADDR      (SRAM_ADDR),
    .Data_to_SRAM   (Data_to_SRAM),
    .Data_from_SRAM (Data_from_SRAM),
    .sram_drive     (sram_drive)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  assign Data_from_SRAM = (!CE && !OE) ? mem[SRAM_ADDR[7:0]] : 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // SRAM model: a write commits on the rising edge of WE while CE is still low.
  always @(negedge Clk) begin
    if (!Reset && !CE && !prev_we_n && WE) begin
      if (!UB) mem[SRAM_ADDR[7:0]][15:8] = Data_to_SRAM[15:8];
      if (!LB) mem[SRAM_ADDR[7:0]][7:0]  = Data_to_SRAM[7:0];
    end
    prev_we_n = WE;
  end

  // Response monitor.
  always @(negedge Clk) begin
    rsp_exp_t e;
    if (Reset) begin
      last_rd = 16'h0;
    end else if (rsp_valid) begin
      n_rsp++;
      if (q_rsp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=1 required=0");
      end else begin
        e = q_rsp.pop_front();
        chk("rsp_latency", cyc - e.acc, WAIT_CYCLES + 2);
        if (e.we) begin
          chk("rsp_rdata_after_write", rsp_rdata, last_rd);
        end else begin
          chk("rsp_rdata", rsp_rdata, e.rdata);
          last_rd = e.rdata;
        end
      end
    end
  end

  // Strobe monitor: per-transaction strobe widths plus cycle-level invariants.
  always @(negedge Clk) begin
    static str_exp_t cur = '{0, 16'h0, 1'b1, 1'b1};
    static int n_oe = 0;
    static int n_we = 0;
    static int n_dr = 0;
    str_exp_t done;
    if (Reset) begin
      busy = 0;
      n_oe = 0;
      n_we = 0;
      n_dr = 0;
    end else begin
      chk("oe_we_exclusive", {31'd0, (!OE && !WE) || (sram_drive && !OE) || (!WE && CE)}, 32'd0);
      if (!req_ready) begin
        if (!busy && q_str.size() != 0) cur = q_str[0];
        busy = 1;
        n_oe += int'(!OE);
        n_we += int'(!WE);
        n_dr += int'(sram_drive);
        if (!CE) chk("lane_strobes", {30'd0, UB, LB}, {30'd0, cur.ub_n, cur.lb_n});
        if (sram_drive) chk("data_to_sram_stable", Data_to_SRAM, cur.wdata);
      end else begin
        if (busy) begin
          if (q_str.size() == 0) begin
            chk("strobe_queue_empty", 32'd1, 32'd0);
          end else begin
            done = q_str.pop_front();
            chk("oe_low_cycles", n_oe, done.we ? 0 : WAIT_CYCLES + 1);
            chk("we_low_cycles", n_we, done.we ? WAIT_CYCLES : 0);
            chk("drive_cycles", n_dr, done.we ? WAIT_CYCLES + 2 : 0);
          end
          busy = 0;
          n_oe = 0;
          n_we = 0;
          n_dr = 0;
        end
        chk("idle_strobes", {26'd0, CE, UB, LB, OE, WE, sram_drive}, 32'b111110);
      end
    end
  end

  task automatic issue(input bit we, input logic [ADDR_W-1:0] a, input logic [15:0] wd,
                       input logic [1:0] be, input logic [15:0] exp_rd, output int acc);
    bit done;
    bit ub_n;
    bit lb_n;
    done = 0;
    acc  = -1;
    ub_n = mask_en ? ~be[1] : 1'b0;
    lb_n = mask_en ? ~be[0] : 1'b0;
    @(posedge Clk);
    #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge Clk);
      if (req_ready) begin
        acc = cyc;
        q_rsp.push_back('{we, exp_rd, cyc});
        q_str.push_back('{we, wd, ub_n, lb_n});
        n_issued++;
        done = 1;
        @(posedge Clk);
        #1;
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    req_valid = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge Clk);
      #1;
      idle = (q_rsp.size() == 0) && (q_str.size() == 0) && req_ready && !busy;
    end
    if (!idle) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int a1, a2, a3, rsp_before;
    bit found;
`ifdef SRAM_BYTE_MASK_EN
    mask_en = 1'b1;
`else
    mask_en = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hBEEF;
    Reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = 16'h0;
    req_be    = 2'b11;

    repeat (2) @(negedge Clk);
    chk("reset_ctrl", {29'd0, req_ready, rsp_valid, sram_drive}, 32'b100);
    chk("reset_strobes", {27'd0, CE, UB, LB, OE, WE}, 32'b11111);
    chk("reset_rdata", rsp_rdata, 16'h0);
    chk("reset_addr_data", {SRAM_ADDR, Data_to_SRAM}, 36'h0);
    #2 Reset = 1'b0;

    issue(1'b0, 20'h00010, 16'h0, 2'b11, 16'hBEEF, a1);
    wait_idle();

    issue(1'b1, 20'h00020, 16'h1234, 2'b11, 16'h0, a1);
    wait_idle();
    chk("model_write_0x20", mem[8'h20], 16'h1234);
    issue(1'b0, 20'h00020, 16'h0, 2'b11, 16'h1234, a1);
    wait_idle();

    // Three back-to-back requests with req_valid never dropping.
    rsp_before = n_rsp;
    issue(1'b1, 20'h00040, 16'h00CD, 2'b11, 16'h0, a1);
    issue(1'b0, 20'h00040, 16'h5A5A, 2'b01, 16'h00CD, a2);
    issue(1'b0, 20'h00010, 16'hFFFF, 2'b11, 16'hBEEF, a3);
    wait_idle();
    chk("accept_spacing_1", a2 - a1, WAIT_CYCLES + 3);
    chk("accept_spacing_2", a3 - a2, WAIT_CYCLES + 3);
    chk("burst_rsp_count", n_rsp - rsp_before, 3);

    issue(1'b1, 20'h00040, 16'hAB00, 2'b10, 16'h0, a1);
    wait_idle();
    issue(1'b0, 20'h00040, 16'h0, 2'b11, mask_en ? 16'hABCD : 16'hAB00, a1);
    wait_idle();

    issue(1'b1, 20'h00040, 16'hFFFF, 2'b00, 16'h0, a1);
    wait_idle();
    issue(1'b0, 20'h00040, 16'h0, 2'b11, mask_en ? 16'hABCD : 16'hFFFF, a1);
    wait_idle();

    // Reset in the middle of a write's ACCESS phase drops the transaction.
    issue(1'b1, 20'h00050, 16'h7777, 2'b11, 16'h0, a1);
    wait_idle();
    issue(1'b1, 20'h00050, 16'h5555, 2'b11, 16'h0, a1);
    req_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge Clk);
      found = !WE;
    end
    chk("reached_access", {31'd0, found}, 32'd1);
    #1 Reset = 1'b1;
    #1;
    chk("async_reset_strobes", {28'd0, CE, WE, sram_drive, rsp_valid}, 32'b1100);
    q_rsp.delete();
    q_str.delete();
    n_issued--;
    @(posedge Clk);
    @(posedge Clk);
    #2 Reset = 1'b0;
    chk("model_after_abort", mem[8'h50], 16'h7777);
    issue(1'b0, 20'h00050, 16'h0, 2'b11, 16'h7777, a1);
    wait_idle();

    chk("total_rsp", n_rsp, n_issued);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
